// File: rtl/counter_pkg.sv
// Shared constants and FSM encoding for the start/clear-controlled up-counter.
package counter_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : counter_pkg

// File: rtl/counter.sv
// Up-counter armed by a start strobe and stopped by a clear strobe; free-running wrap at MAX_COUNT.
module counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter int MAX_COUNT = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             start,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // clr outranks everything; start is ignored once running.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (clr) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_d = RUN;
        end
        RUN: begin
          count_d = (count_q == MAX_Q) ? '0 : count_q + WIDTH'(1);
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  assign q = count_q;

endmodule : counter

// File: tb/tb_counter.sv
// Scoreboard bench for counter: a reference model pushes the expected q per edge, checked 1 ns later.
module tb_counter;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         clr;
  logic         start;
  logic [W-1:0] q;

  int checks;
  int fails;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] expv;
  logic [W-1:0] m_q;
  logic         m_run;

  counter #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .start(start),
    .q    (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs on the falling edge, advance the model, push its prediction, then sample after the edge.
  task automatic step(input logic s, input logic c);
    @(negedge clk);
    start = s;
    clr   = c;
    if (c) begin
      m_q   = '0;
      m_run = 1'b0;
    end else if (!m_run) begin
      if (s) m_run = 1'b1;
    end else begin
      m_q = (m_q == 8'd255) ? 8'd0 : m_q + 8'd1;
    end
    exp_q.push_back(m_q);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    clr   = 1'b0;
    m_q   = '0;
    m_run = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (q !== 8'd0) begin
      $display("FAIL reset_hold: q=%0d expected 0", q);
      fails++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      expv = exp_q.pop_front();
      checks++;
      if (q !== expv) begin
        $display("FAIL reset_idle[%0d]: q=%0d expected %0d", i, q, expv);
        fails++;
      end
    end
  endtask

  task automatic test_start_pulse();
    step(1'b1, 1'b0);
    expv = exp_q.pop_front();
    checks++;
    if (q !== expv) begin
      $display("FAIL start_edge: q=%0d expected %0d", q, expv);
      fails++;
    end
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b0);
      expv = exp_q.pop_front();
      checks++;
      if (q !== expv) begin
        $display("FAIL start_count[%0d]: q=%0d expected %0d", i, q, expv);
        fails++;
      end
    end
    checks++;
    if (q !== 8'd10) begin
      $display("FAIL start_ten: q=%0d expected 10", q);
      fails++;
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 260; i++) begin
      step(1'b0, 1'b0);
      expv = exp_q.pop_front();
      checks++;
      if (q !== expv) begin
        $display("FAIL wrap[%0d]: q=%0d expected %0d", i, q, expv);
        fails++;
      end
    end
    // 10 + 260 = 270 -> 270 mod 256 = 14
    checks++;
    if (q !== 8'd14) begin
      $display("FAIL wrap_final: q=%0d expected 14", q);
      fails++;
    end
  endtask

  task automatic test_clear_mid_run();
    step(1'b0, 1'b1);
    expv = exp_q.pop_front();
    checks++;
    if (q !== expv) begin
      $display("FAIL clr_first: q=%0d expected %0d", q, expv);
      fails++;
    end
    step(1'b1, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0);
      void'(exp_q.pop_front());
    end
    checks++;
    if (q !== 8'd20) begin
      $display("FAIL clr_reach20: q=%0d expected 20", q);
      fails++;
    end
    step(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      expv = exp_q.pop_front();
      checks++;
      if (q !== expv) begin
        $display("FAIL clr_seq[%0d]: q=%0d expected %0d", i, q, expv);
        fails++;
      end
      // three idle cycles, a fresh start, then two counting cycles
      if (i < 5) step((i == 2) ? 1'b1 : 1'b0, 1'b0);
    end
    checks++;
    if (q !== 8'd2) begin
      $display("FAIL clr_resume: q=%0d expected 2", q);
      fails++;
    end
  endtask

  task automatic test_simultaneous();
    // in RUN, then in IDLE
    for (int pass = 0; pass < 2; pass++) begin
      step(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
        expv = exp_q.pop_front();
        checks++;
        if (q !== expv) begin
          $display("FAIL clr_start_p%0d[%0d]: q=%0d expected %0d", pass, i, q, expv);
          fails++;
        end
        if (i < 3) step(1'b0, 1'b0);
      end
    end
    // start held high for several cycles acts like one pulse
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      expv = exp_q.pop_front();
      checks++;
      if (q !== expv) begin
        $display("FAIL start_held[%0d]: q=%0d expected %0d", i, q, expv);
        fails++;
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b1);
    void'(exp_q.pop_front());
    step(1'b1, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 37; i++) begin
      step(1'b0, 1'b0);
      void'(exp_q.pop_front());
    end
    checks++;
    if (q !== 8'd37) begin
      $display("FAIL async_reach37: q=%0d expected 37", q);
      fails++;
    end
    #2;
    rst_n = 1'b0;
    m_q   = '0;
    m_run = 1'b0;
    #1;
    checks++;
    if (q !== 8'd0) begin
      $display("FAIL async_immediate: q=%0d expected 0", q);
      fails++;
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step((i == 3) ? 1'b1 : 1'b0, 1'b0);
      expv = exp_q.pop_front();
      checks++;
      if (q !== expv) begin
        $display("FAIL async_after[%0d]: q=%0d expected %0d", i, q, expv);
        fails++;
      end
    end
    checks++;
    if (q !== 8'd2) begin
      $display("FAIL async_resume: q=%0d expected 2", q);
      fails++;
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_start_pulse();
    test_wrap();
    test_clear_mid_run();
    test_simultaneous();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
      fails++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule : tb_counter
